alu_cmd_sequencer: RTL and testbench



---
 rtl/alu_cmd_sequencer.sv | 168 ++++++++++++++++
 tb/tb_alu_cmd_sequencer.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer
//   Command front-end for the 8-bit combinational 4-op ALU. Commands
//   {load, op, operand} are buffered in a small FIFO. Each one is either
//   loaded straight into the accumulator, or issued to the ALU, held for
//   SETTLE_CYCLES, and captured. Every command returns one response.
//
// Ports
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   cmd_valid/cmd_ready   command handshake (ready = FIFO not full)
//   cmd_load              1 = load cmd_operand into acc, ALU bypassed
//   cmd_op                00 add, 01 sub, 10 shl4, 11 xor
//   cmd_operand           B operand / load value
//   alu_a/alu_b/alu_sel   registered drive to the ALU
//   alu_y                 ALU result, bit 8 = carry/borrow
//   rsp_valid/rsp_ready   response handshake
//   rsp_data/rsp_flag     new accumulator value and captured alu_y[8]
//   acc                   registered accumulator
module alu_cmd_sequencer #(
  parameter int FIFO_DEPTH    = 2,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_load,
  input  logic [1:0] cmd_op,
  input  logic [7:0] cmd_operand,
  output logic [7:0] alu_a,
  output logic [7:0] alu_b,
  output logic [1:0] alu_sel,
  input  logic [8:0] alu_y,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_data,
  output logic       rsp_flag,
  output logic [7:0] acc
);

  localparam int DATA_W  = 8;
  localparam int ENTRY_W = DATA_W + 3;
  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int CNT_W   = $clog2(FIFO_DEPTH + 1);
  localparam int SET_W   = $clog2(SETTLE_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, RESPOND} state_t;

  // Command FIFO
  logic [ENTRY_W-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               push, pop;

  logic               head_load;
  logic [1:0]         head_op;
  logic [DATA_W-1:0]  head_operand;

  // Sequencer state
  state_t             state_q;
  logic [SET_W-1:0]   settle_q;
  logic [DATA_W-1:0]  acc_q;
  logic [DATA_W-1:0]  alu_a_q, alu_b_q;
  logic [1:0]         alu_sel_q;
  logic               rsp_valid_q;
  logic [DATA_W-1:0]  rsp_data_q;
  logic               rsp_flag_q;

  // Ready comes from the registered count only, so a pop in the same
  // cycle never opens an extra slot combinationally.
  assign cmd_ready = (count_q != CNT_W'(FIFO_DEPTH));
  assign push      = cmd_valid && cmd_ready;
  // Pops only happen from IDLE, so the response handshake cycle never pops.
  assign pop       = (state_q == IDLE) && (count_q != '0);

  assign {head_load, head_op, head_operand} = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    // Power-of-two depth: pointer overflow is the modulo wrap.
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    if (push && !pop)      count_d = count_q + CNT_W'(1);
    else if (pop && !push) count_d = count_q - CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is data only; emptiness is tracked by the count.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {cmd_load, cmd_op, cmd_operand};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      settle_q    <= '0;
      acc_q       <= '0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_sel_q   <= 2'b00;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_flag_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pop) begin
            if (head_load) begin
              acc_q       <= head_operand;
              rsp_data_q  <= head_operand;
              rsp_flag_q  <= 1'b0;
              rsp_valid_q <= 1'b1;
              state_q     <= RESPOND;
            end else begin
              alu_a_q   <= acc_q;
              alu_b_q   <= head_operand;
              alu_sel_q <= head_op;
              settle_q  <= SET_W'(SETTLE_CYCLES);
              state_q   <= ISSUE;
            end
          end
        end
        ISSUE: begin
          // Counter loaded with SETTLE_CYCLES gives exactly that many
          // cycles here before capture.
          if (settle_q == SET_W'(1)) state_q <= CAPTURE;
          else                       settle_q <= settle_q - SET_W'(1);
        end
        CAPTURE: begin
          acc_q       <= alu_y[DATA_W-1:0];
          rsp_data_q  <= alu_y[DATA_W-1:0];
          rsp_flag_q  <= alu_y[DATA_W];
          rsp_valid_q <= 1'b1;
          state_q     <= RESPOND;
        end
        RESPOND: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_sel   = alu_sel_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_flag  = rsp_flag_q;
  assign acc       = acc_q;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Testbench for alu_cmd_sequencer: directed command table plus hand-written
// sequences for backpressure/FIFO-full and reset during ISSUE.
module tb_alu_cmd_sequencer;

  localparam int DEPTH   = 2;
  localparam int SETTLE  = 3;
  localparam int LAT_LD  = 1;
  localparam int LAT_ALU = SETTLE + 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_valid, cmd_ready, cmd_load;
  logic [1:0] cmd_op;
  logic [7:0] cmd_operand;
  logic [7:0] alu_a, alu_b;
  logic [1:0] alu_sel;
  logic [8:0] alu_y;
  logic       rsp_valid, rsp_ready, rsp_flag;
  logic [7:0] rsp_data, acc;

  always #5 clk = ~clk;

  alu_cmd_sequencer #(.FIFO_DEPTH(DEPTH), .SETTLE_CYCLES(SETTLE)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_load(cmd_load),
    .cmd_op(cmd_op), .cmd_operand(cmd_operand),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_y(alu_y),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_flag(rsp_flag), .acc(acc)
  );

  // Combinational 4-op ALU the sequencer drives.
  function automatic logic [8:0] alu_model(input logic [7:0] a, input logic [7:0] b,
                                           input logic [1:0] s);
    case (s)
      2'b00:   return {1'b0, a} + {1'b0, b};
      2'b01:   return {1'b0, a} - {1'b0, b};
      2'b10:   return {1'b0, a[3:0], 4'h0};
      default: return {1'b0, a ^ b};
    endcase
  endfunction
  assign alu_y = alu_model(alu_a, alu_b, alu_sel);

  typedef struct {
    logic       load;
    logic [1:0] op;
    logic [7:0] operand;
    logic [7:0] exp_data;
    logic       exp_flag;
  } vec_t;

  vec_t       vecs [9];
  int         n_cmp  = 0;
  int         n_fail = 0;
  logic [7:0] exp_acc, last_a, last_b;
  logic [1:0] last_sel;
  logic [7:0] got_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Offers one command and returns #1 after the accepting edge; cmd_valid
  // is left high so the caller can chain pushes back to back.
  task automatic push(input logic ld, input logic [1:0] op, input logic [7:0] opnd);
    int w = 0;
    while (!cmd_ready && w < 50) begin
      @(posedge clk); #1; w++;
    end
    check("push_ready", cmd_ready, 1);
    cmd_valid = 1'b1; cmd_load = ld; cmd_op = op; cmd_operand = opnd;
    @(posedge clk); #1;
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int lat = 0;
    int bad = 0;
    if (!v.load) begin
      last_a = exp_acc; last_b = v.operand; last_sel = v.op;
    end
    push(v.load, v.op, v.operand);
    cmd_valid = 1'b0;
    while (!rsp_valid && lat < 50) begin
      @(posedge clk); #1; lat++;
      if (alu_a !== last_a || alu_b !== last_b || alu_sel !== last_sel) bad++;
    end
    check($sformatf("v%0d_latency", idx), lat, v.load ? LAT_LD : LAT_ALU);
    check($sformatf("v%0d_alu_stable", idx), bad, 0);
    check($sformatf("v%0d_rsp_data", idx), rsp_data, v.exp_data);
    check($sformatf("v%0d_rsp_flag", idx), rsp_flag, v.exp_flag);
    check($sformatf("v%0d_acc", idx), acc, v.exp_data);
    check($sformatf("v%0d_alu_a", idx), alu_a, last_a);
    check($sformatf("v%0d_alu_b", idx), alu_b, last_b);
    check($sformatf("v%0d_alu_sel", idx), alu_sel, last_sel);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    check($sformatf("v%0d_rsp_valid_drop", idx), rsp_valid, 0);
    exp_acc = v.exp_data;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{1'b1, 2'b00, 8'h3C, 8'h3C, 1'b0};  // load
    vecs[1] = '{1'b0, 2'b00, 8'hD0, 8'h0C, 1'b1};  // add with carry
    vecs[2] = '{1'b0, 2'b01, 8'h0D, 8'hFF, 1'b1};  // sub with borrow
    vecs[3] = '{1'b0, 2'b01, 8'h0F, 8'hF0, 1'b0};  // sub no borrow
    vecs[4] = '{1'b1, 2'b00, 8'hFF, 8'hFF, 1'b0};  // load
    vecs[5] = '{1'b0, 2'b10, 8'hAA, 8'hF0, 1'b0};  // shl4 ignores operand
    vecs[6] = '{1'b0, 2'b11, 8'h0F, 8'hFF, 1'b0};  // xor
    vecs[7] = '{1'b0, 2'b00, 8'h01, 8'h00, 1'b1};  // add wraps to 0
    vecs[8] = '{1'b0, 2'b01, 8'h00, 8'h00, 1'b0};  // equal operands, no borrow

    rst_n = 1'b0; cmd_valid = 1'b0; cmd_load = 1'b0; cmd_op = 2'b00;
    cmd_operand = 8'h00; rsp_ready = 1'b0;
    exp_acc = 8'h00; last_a = 8'h00; last_b = 8'h00; last_sel = 2'b00;
    repeat (3) @(posedge clk);
    #1;
    check("rst_acc", acc, 8'h00);
    check("rst_alu_a", alu_a, 8'h00);
    check("rst_alu_b", alu_b, 8'h00);
    check("rst_alu_sel", alu_sel, 2'b00);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_data", rsp_data, 8'h00);
    check("rst_rsp_flag", rsp_flag, 0);
    check("rst_cmd_ready", cmd_ready, 1);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 9; i++) run_vec(i, vecs[i]);

    // Backpressure: three loads while responses are held off.
    push(1'b1, 2'b00, 8'h11);
    push(1'b1, 2'b00, 8'h22);
    push(1'b1, 2'b00, 8'h33);
    cmd_valid = 1'b0;
    check("bp_cmd_ready_full", cmd_ready, 0);
    check("bp_rsp_valid", rsp_valid, 1);
    check("bp_rsp_data_first", rsp_data, 8'h11);
    // A command offered while full must not be taken.
    cmd_valid = 1'b1; cmd_load = 1'b1; cmd_operand = 8'h44;
    begin
      int unstable = 0;
      for (int c = 0; c < 3; c++) begin
        @(posedge clk); #1;
        if (rsp_data !== 8'h11 || rsp_valid !== 1'b1 || cmd_ready !== 1'b0) unstable++;
      end
      check("bp_hold_stable", unstable, 0);
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      if (rsp_valid) got_q.push_back(rsp_data);
      @(posedge clk); #1;
    end
    rsp_ready = 1'b0;
    check("bp_rsp_count", got_q.size(), 3);
    if (got_q.size() == 3) begin
      check("bp_rsp0", got_q[0], 8'h11);
      check("bp_rsp1", got_q[1], 8'h22);
      check("bp_rsp2", got_q[2], 8'h33);
    end
    check("bp_acc", acc, 8'h33);
    check("bp_cmd_ready_drained", cmd_ready, 1);

    // Reset while an ALU command is in ISSUE and one more is queued.
    push(1'b0, 2'b00, 8'h01);
    push(1'b0, 2'b11, 8'h55);
    cmd_valid = 1'b0;
    check("ar_in_issue_alu_b", alu_b, 8'h01);
    #2 rst_n = 1'b0;
    #1;
    check("ar_acc", acc, 8'h00);
    check("ar_rsp_valid", rsp_valid, 0);
    check("ar_cmd_ready", cmd_ready, 1);
    check("ar_alu_b", alu_b, 8'h00);
    @(posedge clk); #3;
    rst_n = 1'b1;
    rsp_ready = 1'b1;
    begin
      int seen = 0;
      for (int c = 0; c < 15; c++) begin
        @(posedge clk); #1;
        if (rsp_valid) seen++;
      end
      check("ar_no_response", seen, 0);
    end
    rsp_ready = 1'b0;
    exp_acc = 8'h00; last_a = 8'h00; last_b = 8'h00; last_sel = 2'b00;
    run_vec(9, '{1'b1, 2'b00, 8'h5A, 8'h5A, 1'b0});
    run_vec(10, '{1'b0, 2'b11, 8'hA5, 8'hFF, 1'b0});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
